mulf_seq: RTL

//  Parametrised, sequential IEEE-754-style floating-point multiplier for the float unit.

---
 rtl/mulf_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mulf_seq.sv
// Sequential floating-point multiplier with a radix-2 shift-add significand core.
// Fixed latency: MUL for MAN_W+1 cycles, then one NORM cycle, then the result is held in DONE.
module mulf_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   s,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t            state_reg;
  logic [W-1:0]      op_reg [2];
  logic [PW-1:0]     mcand_reg;
  logic [MAN_W:0]    mplier_reg;
  logic [PW-1:0]     acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic [W-1:0]      s_reg, s_next;
  logic [3:0]        flags_reg, flags_next;
  logic              in_ready_reg, out_valid_reg;

  // Operand classification, shared by both operands.
  logic [1:0] is_zero, is_inf, is_nan;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      logic [EXP_W-1:0] ex;
      logic [MAN_W-1:0] fr;
      assign ex          = op_reg[gi][W-2:MAN_W];
      assign fr          = op_reg[gi][MAN_W-1:0];
      assign is_zero[gi] = (ex == '0);
      assign is_inf[gi]  = (&ex) & ~(|fr);
      assign is_nan[gi]  = (&ex) & (|fr);
    end
  endgenerate

  logic                    sign;
  logic signed [EXP_W+1:0] e_base, e_norm, e_fin;
  logic                    hi, guard, sticky, inc;
  logic [MAN_W-1:0]        frac_t;
  logic [MAN_W:0]          frac_r;

  assign sign   = op_reg[0][W-1] ^ op_reg[1][W-1];
  assign e_base = $signed({2'b00, op_reg[0][W-2:MAN_W]}) + $signed({2'b00, op_reg[1][W-2:MAN_W]}) - BIAS_S;

  always_comb begin
    hi = acc_reg[PW-1];
    if (hi) begin
      frac_t = acc_reg[PW-2 -: MAN_W];
      guard  = acc_reg[MAN_W];
      sticky = |acc_reg[MAN_W-1:0];
    end else begin
      frac_t = acc_reg[PW-3 -: MAN_W];
      guard  = acc_reg[MAN_W-1];
      sticky = |acc_reg[MAN_W-2:0];
    end
    e_norm = e_base + {{(EXP_W+1){1'b0}}, hi};
    inc    = guard & (sticky | frac_t[0]);
    frac_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    // A rounding carry leaves the fraction field at zero and bumps the exponent.
    e_fin  = e_norm + {{(EXP_W+1){1'b0}}, frac_r[MAN_W]};

    s_next     = {sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_next = {3'b000, guard | sticky};
    if ((|is_nan) || ((|is_inf) && (|is_zero))) begin
      s_next     = QNAN;
      flags_next = 4'b1000;
    end else if (|is_inf) begin
      s_next     = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_next = 4'b0000;
    end else if (|is_zero) begin
      s_next     = {sign, {(W-1){1'b0}}};
      flags_next = 4'b0000;
    end else if (e_fin >= EMAX_S) begin
      s_next     = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_next = 4'b0101;
    end else if (e_fin[EXP_W+1] || (e_fin == '0)) begin
      s_next     = {sign, {(W-1){1'b0}}};
      flags_next = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg[0]     <= '0;
      op_reg[1]     <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      s_reg         <= '0;
      flags_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg[0]    <= a;
            op_reg[1]    <= b;
            mcand_reg    <= PW'({1'b1, a[MAN_W-1:0]});
            mplier_reg   <= {1'b1, b[MAN_W-1:0]};
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL;
          end
        end
        MUL: begin
          // Zero/special operands still run the full loop so latency never varies.
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(MAN_W)) state_reg <= NORM;
        end
        NORM: begin
          s_reg         <= s_next;
          flags_reg     <= flags_next;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign flags     = flags_reg;

endmodule
